// File: rtl/bm_engine_dispatcher_if.sv
// Job channel and per-engine control bus between the block-match control FSM,
// the dispatcher (slave) and the engine bank; the master modport is the environment side.
interface bm_engine_dispatcher_if #(
   parameter int unsigned NUM_ENG = 2,
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned IDX_W   = 16
) ();
   logic                      job_valid;
   logic                      job_ready;
   logic [ADDR_W-1:0]         job_blk_addr;
   logic [ADDR_W-1:0]         job_srch_addr;
   logic [IDX_W-1:0]          job_index;
   logic [NUM_ENG-1:0]        eng_start;
   logic [NUM_ENG*ADDR_W-1:0] eng_blk_addr;
   logic [NUM_ENG*ADDR_W-1:0] eng_srch_addr;
   logic [NUM_ENG*IDX_W-1:0]  eng_index;
   logic [NUM_ENG-1:0]        eng_done;

   modport master (
      output job_valid, job_blk_addr, job_srch_addr, job_index, eng_done,
      input  job_ready, eng_start, eng_blk_addr, eng_srch_addr, eng_index
   );

   modport slave (
      input  job_valid, job_blk_addr, job_srch_addr, job_index, eng_done,
      output job_ready, eng_start, eng_blk_addr, eng_srch_addr, eng_index
   );
endinterface

// File: rtl/bm_engine_dispatcher.sv
// Round-robin job dispatcher for a bank of block-match engines: accepts one job per
// handshake, runs a start/done handshake per engine and tracks completion statistics.
module bm_engine_dispatcher #(
   parameter int unsigned NUM_ENG = 2,
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned IDX_W   = 16,
   parameter int unsigned CNT_W   = 16,
   localparam int unsigned INF_W  = $clog2(NUM_ENG + 1),
   localparam int unsigned PTR_W  = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   bm_engine_dispatcher_if.slave bus,
   output logic [INF_W-1:0]     inflight,
   output logic [CNT_W-1:0]     jobs_done,
   output logic                 all_idle
);

   typedef enum logic [1:0] {EIdle, EStart, EBusy} eng_state_e;

   eng_state_e         state_q [NUM_ENG];
   logic [NUM_ENG-1:0] start_q;
   logic [ADDR_W-1:0]  blk_q   [NUM_ENG];
   logic [ADDR_W-1:0]  srch_q  [NUM_ENG];
   logic [IDX_W-1:0]   idx_q   [NUM_ENG];
   logic [PTR_W-1:0]   rr_ptr_q;
   logic [CNT_W-1:0]   jobs_done_q;

   logic [NUM_ENG-1:0] avail;
   logic [NUM_ENG-1:0] grant_oh;
   logic [PTR_W-1:0]   grant_idx;
   logic [CNT_W-1:0]   n_complete;
   logic               found;
   logic               accept;
   int unsigned        cand;

   always_comb begin
      avail      = '0;
      inflight   = '0;
      n_complete = '0;
      for (int unsigned i = 0; i < NUM_ENG; i++) begin
         avail[i] = (state_q[i] == EIdle) && bus.eng_done[i];
         if (state_q[i] != EIdle) inflight = inflight + INF_W'(1);
         if ((state_q[i] == EBusy) && bus.eng_done[i]) n_complete = n_complete + CNT_W'(1);
      end
   end

   // Search starts one past the last granted engine so every idle engine gets its turn.
   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = 0;
      for (int unsigned k = 1; k <= NUM_ENG; k++) begin
         cand = (32'(rr_ptr_q) + k) % NUM_ENG;
         if (!found && avail[PTR_W'(cand)]) begin
            found                  = 1'b1;
            grant_oh[PTR_W'(cand)] = 1'b1;
            grant_idx              = PTR_W'(cand);
         end
      end
   end

   assign bus.job_ready = |avail;
   assign accept        = bus.job_valid && bus.job_ready;
   assign all_idle      = &avail;
   assign jobs_done     = jobs_done_q;
   assign bus.eng_start = start_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_ENG; i++) begin
            state_q[i] <= EIdle;
            blk_q[i]   <= '0;
            srch_q[i]  <= '0;
            idx_q[i]   <= '0;
         end
         start_q     <= '0;
         rr_ptr_q    <= PTR_W'(NUM_ENG - 1);
         jobs_done_q <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_ENG; i++) begin
            case (state_q[i])
               EIdle: begin
                  if (accept && grant_oh[i]) begin
                     state_q[i] <= EStart;
                     start_q[i] <= 1'b1;
                     blk_q[i]   <= bus.job_blk_addr;
                     srch_q[i]  <= bus.job_srch_addr;
                     idx_q[i]   <= bus.job_index;
                  end
               end
               // Start is held until the engine acknowledges by dropping done.
               EStart: begin
                  if (!bus.eng_done[i]) begin
                     state_q[i] <= EBusy;
                     start_q[i] <= 1'b0;
                  end
               end
               EBusy: begin
                  if (bus.eng_done[i]) state_q[i] <= EIdle;
               end
               default: begin
                  state_q[i] <= EIdle;
                  start_q[i] <= 1'b0;
               end
            endcase
         end
         if (accept) rr_ptr_q <= grant_idx;
         jobs_done_q <= jobs_done_q + n_complete;
      end
   end

   for (genvar g = 0; g < NUM_ENG; g++) begin : gen_slices
      assign bus.eng_blk_addr[g*ADDR_W +: ADDR_W]  = blk_q[g];
      assign bus.eng_srch_addr[g*ADDR_W +: ADDR_W] = srch_q[g];
      assign bus.eng_index[g*IDX_W +: IDX_W]       = idx_q[g];
   end

endmodule

// File: tb/tb_bm_engine_dispatcher.sv
// Directed bench for bm_engine_dispatcher: a two-engine instance for dispatch behaviour
// and a one-engine, 4-bit-counter instance for completion-counter wrap.
module tb_bm_engine_dispatcher;

   logic        clk;
   logic        reset;
   logic [1:0]  inflight;
   logic [15:0] jobs_done;
   logic        all_idle;
   logic [0:0]  s_inflight;
   logic [3:0]  s_jobs_done;
   logic        s_all_idle;
   int          n_tests;
   int          n_fail;

   bm_engine_dispatcher_if #(.NUM_ENG(2), .ADDR_W(16), .IDX_W(16)) bus ();
   bm_engine_dispatcher_if #(.NUM_ENG(1), .ADDR_W(16), .IDX_W(16)) sbus ();

   bm_engine_dispatcher #(.NUM_ENG(2), .ADDR_W(16), .IDX_W(16), .CNT_W(16)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .inflight  (inflight),
      .jobs_done (jobs_done),
      .all_idle  (all_idle)
   );

   bm_engine_dispatcher #(.NUM_ENG(1), .ADDR_W(16), .IDX_W(16), .CNT_W(4)) u_dut_small (
      .clk       (clk),
      .reset     (reset),
      .bus       (sbus),
      .inflight  (s_inflight),
      .jobs_done (s_jobs_done),
      .all_idle  (s_all_idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic set_job(input logic [15:0] blk, input logic [15:0] srch, input logic [15:0] idx);
      bus.job_blk_addr  = blk;
      bus.job_srch_addr = srch;
      bus.job_index     = idx;
   endtask

   task automatic test_reset();
      bus.job_valid = 1'b0;
      bus.eng_done  = 2'b11;
      set_job(16'h0, 16'h0, 16'h0);
      do_reset();
      n_tests++; if (bus.eng_start !== 2'b00) begin n_fail++;
         $display("FAIL reset_start: got %b expected %b", bus.eng_start, 2'b00); end
      n_tests++; if (inflight !== 2'd0) begin n_fail++;
         $display("FAIL reset_inflight: got %0d expected 0", inflight); end
      n_tests++; if (jobs_done !== 16'h0) begin n_fail++;
         $display("FAIL reset_jobs_done: got %h expected 0000", jobs_done); end
      n_tests++; if (bus.job_ready !== 1'b1 || all_idle !== 1'b1) begin n_fail++;
         $display("FAIL reset_ready_idle: got ready=%b idle=%b expected 1 1", bus.job_ready, all_idle); end
      n_tests++; if (bus.eng_blk_addr !== 32'h0 || bus.eng_index !== 32'h0) begin n_fail++;
         $display("FAIL reset_fields: got blk=%h idx=%h expected 0", bus.eng_blk_addr, bus.eng_index); end
      bus.eng_done = 2'b10;
      #1;
      n_tests++; if (all_idle !== 1'b0 || bus.job_ready !== 1'b1) begin n_fail++;
         $display("FAIL idle_follows_done: got idle=%b ready=%b expected 0 1", all_idle, bus.job_ready); end
      bus.eng_done = 2'b11;
      #1;
   endtask

   task automatic test_single_job();
      set_job(16'h0010, 16'h0100, 16'h0001);
      bus.job_valid = 1'b1;
      tick();
      bus.job_valid = 1'b0;
      n_tests++; if (bus.eng_start !== 2'b01) begin n_fail++;
         $display("FAIL single_start: got %b expected 01", bus.eng_start); end
      n_tests++; if (bus.eng_blk_addr[15:0] !== 16'h0010 || bus.eng_srch_addr[15:0] !== 16'h0100
                     || bus.eng_index[15:0] !== 16'h0001) begin n_fail++;
         $display("FAIL single_fields: got blk=%h srch=%h idx=%h expected 0010 0100 0001",
                  bus.eng_blk_addr[15:0], bus.eng_srch_addr[15:0], bus.eng_index[15:0]); end
      n_tests++; if (inflight !== 2'd1 || bus.job_ready !== 1'b1 || all_idle !== 1'b0) begin n_fail++;
         $display("FAIL single_status: got inflight=%0d ready=%b idle=%b expected 1 1 0",
                  inflight, bus.job_ready, all_idle); end
      bus.eng_done = 2'b10;
      tick();
      n_tests++; if (bus.eng_start !== 2'b00 || inflight !== 2'd1) begin n_fail++;
         $display("FAIL single_busy: got start=%b inflight=%0d expected 00 1", bus.eng_start, inflight); end
      bus.eng_done = 2'b11;
      tick();
      n_tests++; if (jobs_done !== 16'd1 || inflight !== 2'd0 || all_idle !== 1'b1) begin n_fail++;
         $display("FAIL single_done: got jobs=%0d inflight=%0d idle=%b expected 1 0 1",
                  jobs_done, inflight, all_idle); end
      n_tests++; if (bus.eng_blk_addr[15:0] !== 16'h0010) begin n_fail++;
         $display("FAIL single_fields_kept: got %h expected 0010", bus.eng_blk_addr[15:0]); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      set_job(16'h0A00, 16'h0A10, 16'h00A1);
      bus.job_valid = 1'b1;
      tick();
      set_job(16'h0B00, 16'h0B10, 16'h00B1);
      tick();
      bus.job_valid = 1'b0;
      n_tests++; if (bus.eng_start !== 2'b11 || inflight !== 2'd2 || bus.job_ready !== 1'b0) begin n_fail++;
         $display("FAIL b2b_status: got start=%b inflight=%0d ready=%b expected 11 2 0",
                  bus.eng_start, inflight, bus.job_ready); end
      n_tests++; if (bus.eng_blk_addr !== 32'h0B00_0A00 || bus.eng_index !== 32'h00B1_00A1) begin n_fail++;
         $display("FAIL b2b_fields: got blk=%h idx=%h expected 0b000a00 00b100a1",
                  bus.eng_blk_addr, bus.eng_index); end
      bus.eng_done = 2'b00;
      tick();
      n_tests++; if (bus.eng_start !== 2'b00 || inflight !== 2'd2) begin n_fail++;
         $display("FAIL b2b_busy: got start=%b inflight=%0d expected 00 2", bus.eng_start, inflight); end
      bus.eng_done = 2'b01;
      tick();
      n_tests++; if (jobs_done !== 16'd1 || inflight !== 2'd1 || bus.job_ready !== 1'b1) begin n_fail++;
         $display("FAIL b2b_first_done: got jobs=%0d inflight=%0d ready=%b expected 1 1 1",
                  jobs_done, inflight, bus.job_ready); end
      bus.eng_done = 2'b11;
      tick();
      n_tests++; if (jobs_done !== 16'd2 || inflight !== 2'd0) begin n_fail++;
         $display("FAIL b2b_second_done: got jobs=%0d inflight=%0d expected 2 0", jobs_done, inflight); end
   endtask

   task automatic test_round_robin_skip();
      do_reset();
      set_job(16'h0C00, 16'h0C10, 16'h0C00);
      bus.job_valid = 1'b1;
      tick();
      bus.job_valid = 1'b0;
      bus.eng_done  = 2'b10;
      tick();
      set_job(16'h0C01, 16'h0C11, 16'h0C01);
      bus.job_valid = 1'b1;
      tick();
      bus.job_valid = 1'b0;
      n_tests++; if (bus.eng_start !== 2'b10 || bus.eng_index[31:16] !== 16'h0C01 || bus.job_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rr_first_to_eng1: got start=%b idx1=%h ready=%b expected 10 0c01 0",
                  bus.eng_start, bus.eng_index[31:16], bus.job_ready); end
      bus.eng_done = 2'b00;
      tick();
      bus.eng_done = 2'b10;
      tick();
      set_job(16'h0C02, 16'h0C12, 16'h0C02);
      bus.job_valid = 1'b1;
      tick();
      bus.job_valid = 1'b0;
      n_tests++; if (bus.eng_start !== 2'b10 || bus.eng_index !== 32'h0C02_0C00 || jobs_done !== 16'd1) begin
         n_fail++;
         $display("FAIL rr_skip_eng0: got start=%b idx=%h jobs=%0d expected 10 0c020c00 1",
                  bus.eng_start, bus.eng_index, jobs_done); end
      bus.eng_done = 2'b00;
      tick();
      bus.eng_done = 2'b10;
      tick();
      // eng0 completes in the same edge that eng1 is granted a new job
      set_job(16'h0C03, 16'h0C13, 16'h0C03);
      bus.job_valid = 1'b1;
      bus.eng_done  = 2'b11;
      tick();
      bus.job_valid = 1'b0;
      n_tests++; if (bus.eng_start !== 2'b10 || inflight !== 2'd1 || jobs_done !== 16'd3
                     || bus.eng_index[31:16] !== 16'h0C03) begin n_fail++;
         $display("FAIL rr_grant_and_complete: got start=%b inflight=%0d jobs=%0d idx1=%h expected 10 1 3 0c03",
                  bus.eng_start, inflight, jobs_done, bus.eng_index[31:16]); end
      bus.eng_done = 2'b01;
      tick();
      bus.eng_done = 2'b11;
      tick();
      n_tests++; if (jobs_done !== 16'd4 || inflight !== 2'd0) begin n_fail++;
         $display("FAIL rr_final: got jobs=%0d inflight=%0d expected 4 0", jobs_done, inflight); end
   endtask

   task automatic test_start_held();
      set_job(16'h0D00, 16'h0D10, 16'h0D00);
      bus.job_valid = 1'b1;
      tick();
      n_tests++; if (bus.eng_start !== 2'b01) begin n_fail++;
         $display("FAIL held_first_to_eng0: got %b expected 01", bus.eng_start); end
      set_job(16'h0D01, 16'h0D11, 16'h0D01);
      tick();
      for (int c = 0; c < 5; c++) begin
         tick();
         n_tests++; if (bus.eng_start !== 2'b11 || bus.job_ready !== 1'b0
                        || bus.eng_index !== 32'h0D01_0D00) begin n_fail++;
            $display("FAIL held_cycle%0d: got start=%b ready=%b idx=%h expected 11 0 0d010d00",
                     c, bus.eng_start, bus.job_ready, bus.eng_index); end
      end
      bus.job_valid = 1'b0;
      n_tests++; if (inflight !== 2'd2 || jobs_done !== 16'd4) begin n_fail++;
         $display("FAIL held_status: got inflight=%0d jobs=%0d expected 2 4", inflight, jobs_done); end
   endtask

   task automatic test_reset_mid_job();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_tests++; if (bus.eng_start !== 2'b00 || inflight !== 2'd0 || jobs_done !== 16'd0) begin n_fail++;
         $display("FAIL midreset_state: got start=%b inflight=%0d jobs=%0d expected 00 0 0",
                  bus.eng_start, inflight, jobs_done); end
      n_tests++; if (bus.eng_blk_addr !== 32'h0 || bus.eng_index !== 32'h0 || all_idle !== 1'b1) begin n_fail++;
         $display("FAIL midreset_fields: got blk=%h idx=%h idle=%b expected 0 0 1",
                  bus.eng_blk_addr, bus.eng_index, all_idle); end
      set_job(16'h0E00, 16'h0E10, 16'h0E00);
      bus.job_valid = 1'b1;
      tick();
      bus.job_valid = 1'b0;
      n_tests++; if (bus.eng_start !== 2'b01 || bus.eng_index[15:0] !== 16'h0E00) begin n_fail++;
         $display("FAIL midreset_first_grant: got start=%b idx0=%h expected 01 0e00",
                  bus.eng_start, bus.eng_index[15:0]); end
   endtask

   task automatic test_counter_wrap();
      for (int i = 0; i < 16; i++) begin
         sbus.job_index = 16'(i);
         sbus.job_valid = 1'b1;
         tick();
         sbus.job_valid = 1'b0;
         n_tests++; if (sbus.eng_start !== 1'b1 || sbus.eng_index !== 16'(i)) begin n_fail++;
            $display("FAIL wrap_start%0d: got start=%b idx=%h expected 1 %h", i, sbus.eng_start,
                     sbus.eng_index, 16'(i)); end
         sbus.eng_done = 1'b0;
         tick();
         sbus.eng_done = 1'b1;
         tick();
         if (i == 14) begin
            n_tests++; if (s_jobs_done !== 4'hF) begin n_fail++;
               $display("FAIL wrap_max: got %h expected f", s_jobs_done); end
         end
      end
      n_tests++; if (s_jobs_done !== 4'h0 || s_all_idle !== 1'b1) begin n_fail++;
         $display("FAIL wrap_zero: got jobs=%h idle=%b expected 0 1", s_jobs_done, s_all_idle); end
   endtask

   initial begin
      n_tests            = 0;
      n_fail             = 0;
      reset              = 1'b1;
      sbus.job_valid     = 1'b0;
      sbus.job_blk_addr  = 16'h1234;
      sbus.job_srch_addr = 16'h5678;
      sbus.job_index     = 16'h0;
      sbus.eng_done      = 1'b1;
      test_reset();
      test_single_job();
      test_back_to_back();
      test_round_robin_skip();
      test_start_held();
      test_reset_mid_job();
      test_counter_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
